// File: rtl/eth_tx_framer_if.sv
// Byte-stream port of the Ethernet TX framer.
// A byte moves on a rising clk edge where tx_valid && tx_ready; tx_data/tx_last must be stable
// while tx_valid is high; tx_ready never depends on tx_valid; tx_err = tx_ready && !tx_valid.
interface eth_tx_framer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_err;

    modport master (output tx_valid, tx_data, tx_last, input tx_ready, tx_err);
    modport slave  (input tx_valid, tx_data, tx_last, output tx_ready, tx_err);
endinterface

// File: rtl/eth_tx_framer.sv
// Bit-serial Ethernet TX sequencer: preamble/SFD, LSB-first payload, FCS from an external eth_fcs, IFG.
// Define ETH_TX_PAD_EN to zero-pad payloads shorter than MIN_BYTES (pad bytes are CRC'd).
module eth_tx_framer #(
    parameter int PRE_BYTES = 7,
    parameter int IFG_BITS  = 96,
    parameter int MIN_BYTES = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    eth_tx_framer_if.slave       s,
    output logic                 txd,
    output logic                 tx_en,
    output logic                 crc_rst,
    output logic                 crc_en,
    output logic                 crc_bit,
    input  logic [31:0]          crc_val,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_FCS  = 3'd4,
        ST_IFG  = 3'd5
`ifdef ETH_TX_PAD_EN
        , ST_PAD = 3'd6
`endif
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRE_BYTES * 8 - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BITS - 1);
    localparam logic [7:0]  SFD      = 8'hD5;

    state_t      state;
    logic [15:0] bit_cnt;
    logic [15:0] byte_cnt;
    logic [15:0] byte_cnt_inc;
    logic [6:0]  shift;
    logic [31:0] fcs_sh;
    logic        last_q;
    logic        tx_ready_q;
    logic        txd_q;

    assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign s.tx_ready   = tx_ready_q;
    assign s.tx_err     = tx_ready_q & ~s.tx_valid;
    assign dbg_state    = state;
    // The engine absorbed the last data bit at the edge that entered FCS, so its
    // result is only valid from the first FCS cycle on: send that bit straight through.
    assign txd = (state == ST_FCS && bit_cnt == 16'd0) ? ~crc_val[31] : txd_q;

`ifdef ETH_TX_PAD_EN
    localparam logic [15:0] MIN_CNT = 16'(MIN_BYTES);
`else
    logic unused_cfg;
    assign unused_cfg = (MIN_BYTES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            fcs_sh     <= '0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            txd_q      <= 1'b0;
            tx_en      <= 1'b0;
            crc_rst    <= 1'b1;
            crc_en     <= 1'b0;
            crc_bit    <= 1'b0;
        end else if (tx_ready_q) begin
            // Fetch cycle (last SFD bit or bit 7 of a non-last byte): load or abort.
            tx_ready_q <= 1'b0;
            bit_cnt    <= '0;
            if (s.tx_valid) begin
                state    <= ST_DATA;
                shift    <= s.tx_data[7:1];
                last_q   <= s.tx_last;
                txd_q    <= s.tx_data[0];
                crc_bit  <= s.tx_data[0];
                crc_en   <= 1'b1;
                crc_rst  <= 1'b0;
                byte_cnt <= byte_cnt_inc;
            end else begin
                state   <= ST_IFG;
                txd_q   <= 1'b0;
                tx_en   <= 1'b0;
                crc_rst <= 1'b1;
                crc_en  <= 1'b0;
                crc_bit <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    crc_rst <= 1'b1;
                    if (s.tx_valid) begin
                        state    <= ST_PRE;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        txd_q    <= 1'b1;
                        tx_en    <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (bit_cnt == PRE_LAST) begin
                        state   <= ST_SFD;
                        bit_cnt <= '0;
                        txd_q   <= SFD[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                        txd_q   <= ~txd_q;
                    end
                end
                ST_SFD: begin
                    bit_cnt <= bit_cnt + 16'd1;
                    txd_q   <= SFD[bit_cnt[2:0] + 3'd1];
                    if (bit_cnt[2:0] == 3'd6) tx_ready_q <= 1'b1;
                end
                ST_DATA: begin
                    bit_cnt <= bit_cnt + 16'd1;
                    shift   <= {1'b0, shift[6:1]};
                    txd_q   <= shift[0];
                    crc_bit <= shift[0];
                    if (bit_cnt[2:0] == 3'd6 && !last_q) tx_ready_q <= 1'b1;
                    // Bit 7 only lands here for the last byte; other bytes go through the fetch branch.
                    if (bit_cnt[2:0] == 3'd7) begin
                        bit_cnt <= '0;
                        txd_q   <= 1'b0;
                        crc_bit <= 1'b0;
`ifdef ETH_TX_PAD_EN
                        if (byte_cnt < MIN_CNT) begin
                            state    <= ST_PAD;
                            byte_cnt <= byte_cnt_inc;
                        end else begin
                            state  <= ST_FCS;
                            crc_en <= 1'b0;
                        end
`else
                        state  <= ST_FCS;
                        crc_en <= 1'b0;
`endif
                    end
                end
`ifdef ETH_TX_PAD_EN
                ST_PAD: begin
                    bit_cnt <= bit_cnt + 16'd1;
                    if (bit_cnt[2:0] == 3'd7) begin
                        bit_cnt <= '0;
                        if (byte_cnt < MIN_CNT) begin
                            byte_cnt <= byte_cnt_inc;
                        end else begin
                            state  <= ST_FCS;
                            crc_en <= 1'b0;
                        end
                    end
                end
`endif
                ST_FCS: begin
                    bit_cnt <= bit_cnt + 16'd1;
                    if (bit_cnt[4:0] == 5'd0) begin
                        fcs_sh <= {~crc_val[29:0], 2'b00};
                        txd_q  <= ~crc_val[30];
                    end else if (bit_cnt[4:0] == 5'd31) begin
                        state   <= ST_IFG;
                        bit_cnt <= '0;
                        txd_q   <= 1'b0;
                        tx_en   <= 1'b0;
                        crc_rst <= 1'b1;
                    end else begin
                        txd_q  <= fcs_sh[31];
                        fcs_sh <= {fcs_sh[30:0], 1'b0};
                    end
                end
                ST_IFG: begin
                    if (bit_cnt == IFG_LAST) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
